// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial add/subtract controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Bit-counter width; a 2-bit operand still needs one counter bit.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/FA_X1.sv
// Single full-adder cell, the only arithmetic element of the serial adder.
module FA_X1 (
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic CO,
    output logic S
);

    assign S  = A ^ B ^ CI;
    assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one FA_X1 cell stepped over WIDTH bits, LSB first,
// framed by a start/busy/done handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OVF
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             c_q;
    logic             cmsb_q;
    logic [CNT_W-1:0] count;
    logic             fa_co;
    logic             fa_s;
    logic             accept;

    FA_X1 u_fa (a_sr[0], b_sr[0], c_q, fa_co, fa_s);

    assign accept = START && (state == ST_IDLE || state == ST_FIN);

    // Subtraction is A + ~B + 1, so the inversion happens at load and the +1
    // rides in through the carry flop.
    always_ff @(posedge CK) begin
        if (!RN) begin
            state  <= ST_IDLE;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            c_q    <= 1'b0;
            cmsb_q <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    DONE <= 1'b0;
                    if (accept) begin
                        state <= ST_RUN;
                        BUSY  <= 1'b1;
                        a_sr  <= A;
                        b_sr  <= SUB ? ~B : B;
                        c_q   <= SUB ? 1'b1 : CI;
                        s_sr  <= '0;
                        count <= '0;
                    end else begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
                    c_q   <= fa_co;
                    count <= count + 1'b1;
                    // The carry entering the MSB is kept for overflow detection.
                    if (count == LAST_BIT) begin
                        cmsb_q <= c_q;
                        state  <= ST_FIN;
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

    assign S   = s_sr;
    assign CO  = c_q;
    assign OVF = cmsb_q ^ c_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed plan cases plus randomized
// operations compared against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         CK;
    logic         RN;
    logic         START;
    logic         SUB;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CI;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] S;
    logic         CO;
    logic         OVF;

    int assertCount = 0;
    int failCount   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .CK(CK), .RN(RN), .START(START), .SUB(SUB), .A(A), .B(B), .CI(CI),
        .BUSY(BUSY), .DONE(DONE), .S(S), .CO(CO), .OVF(OVF)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference result as {OVF, CO, S} from plain two's-complement arithmetic.
    function automatic logic [W+1:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic ci, input logic sub);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : ci)};
        ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {ovf, full[W], full[W-1:0]};
    endfunction

    // Presents an operation with START high; returns one step after the accept edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sub);
        A = a; B = b; CI = ci; SUB = sub; START = 1'b1;
        @(posedge CK); #1;
        START = 1'b0;
    endtask

    // Walks cycles 1..W of a running operation then checks the DONE cycle.
    // glitchCycle != 0 pulses START with junk operands during that RUN cycle.
    task automatic checkOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic sub, input int glitchCycle);
        logic [W+1:0] exp;
        exp = refModel(a, b, ci, sub);
        for (int i = 1; i <= W; i++) begin
            checkOutput({tag, " busy"}, {31'd0, BUSY}, 32'd1);
            if (i == 1 || i == W || i == glitchCycle)
                checkOutput({tag, " done-low"}, {31'd0, DONE}, 32'd0);
            if (i == glitchCycle) begin
                START = 1'b1; A = W'($urandom); B = W'($urandom);
                CI = 1'($urandom); SUB = 1'($urandom);
            end else begin
                START = 1'b0;
            end
            @(posedge CK); #1;
        end
        START = 1'b0;
        checkOutput({tag, " done"}, {31'd0, DONE}, 32'd1);
        checkOutput({tag, " busy-low"}, {31'd0, BUSY}, 32'd0);
        checkOutput({tag, " S"}, {24'd0, S}, {24'd0, exp[W-1:0]});
        checkOutput({tag, " CO"}, {31'd0, CO}, {31'd0, exp[W]});
        checkOutput({tag, " OVF"}, {31'd0, OVF}, {31'd0, exp[W+1]});
    endtask

    // After a DONE cycle with START low: back to idle, result held.
    task automatic checkIdle(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic ci, input logic sub);
        logic [W+1:0] exp;
        exp = refModel(a, b, ci, sub);
        @(posedge CK); #1;
        checkOutput({tag, " idle done"}, {31'd0, DONE}, 32'd0);
        checkOutput({tag, " idle busy"}, {31'd0, BUSY}, 32'd0);
        checkOutput({tag, " hold S"}, {24'd0, S}, {24'd0, exp[W-1:0]});
    endtask

    task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sub);
        applyStimulus(a, b, ci, sub);
        checkOp(tag, a, b, ci, sub, 0);
        checkIdle(tag, a, b, ci, sub);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        int           glitch;

        RN = 1'b0; START = 1'b1; SUB = 1'b0; A = 8'hAA; B = 8'h55; CI = 1'b1;
        repeat (2) @(posedge CK);
        #1;
        checkOutput("reset BUSY", {31'd0, BUSY}, 32'd0);
        checkOutput("reset DONE", {31'd0, DONE}, 32'd0);
        checkOutput("reset S", {24'd0, S}, 32'd0);
        checkOutput("reset CO", {31'd0, CO}, 32'd0);
        checkOutput("reset OVF", {31'd0, OVF}, 32'd0);
        START = 1'b0; RN = 1'b1;
        @(posedge CK); #1;

        runOp("add5A33", 8'h5A, 8'h33, 1'b0, 1'b0);
        checkOutput("add5A33 const S", {24'd0, S}, 32'h8D);
        runOp("addFF00c", 8'hFF, 8'h00, 1'b1, 1'b0);
        runOp("addFFFFc", 8'hFF, 8'hFF, 1'b1, 1'b0);
        runOp("sub1020", 8'h10, 8'h20, 1'b0, 1'b1);
        runOp("sub8001", 8'h80, 8'h01, 1'b1, 1'b1);
        checkOutput("sub8001 const S", {24'd0, S}, 32'h7F);

        // START pulsed during RUN must not disturb the in-flight operation.
        applyStimulus(8'h3C, 8'h47, 1'b1, 1'b0);
        checkOp("glitch", 8'h3C, 8'h47, 1'b1, 1'b0, 3);
        checkIdle("glitch", 8'h3C, 8'h47, 1'b1, 1'b0);

        // START asserted in the DONE cycle chains straight into the next op.
        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0);
        checkOp("b2b-1", 8'h7F, 8'h01, 1'b0, 1'b0, 0);
        applyStimulus(8'h01, 8'h02, 1'b0, 1'b1);
        checkOp("b2b-2", 8'h01, 8'h02, 1'b0, 1'b1, 0);
        checkIdle("b2b-2", 8'h01, 8'h02, 1'b0, 1'b1);

        // Reset in the 4th RUN cycle aborts the operation.
        applyStimulus(8'hC3, 8'h5A, 1'b1, 1'b0);
        repeat (3) begin @(posedge CK); #1; end
        RN = 1'b0;
        @(posedge CK); #1;
        RN = 1'b1;
        checkOutput("abort BUSY", {31'd0, BUSY}, 32'd0);
        checkOutput("abort DONE", {31'd0, DONE}, 32'd0);
        checkOutput("abort S", {24'd0, S}, 32'd0);
        checkOutput("abort CO", {31'd0, CO}, 32'd0);
        checkOutput("abort OVF", {31'd0, OVF}, 32'd0);
        @(posedge CK); #1;
        checkOutput("abort stays idle", {31'd0, BUSY}, 32'd0);

        // Every full-adder input combination through the operand LSBs.
        for (int k = 0; k < 8; k++) begin
            ra = {W'($urandom) >> 1, 1'(k >> 2)};
            rb = {W'($urandom) >> 1, 1'(k >> 1)};
            runOp($sformatf("fa%0d", k), {ra[W-1:1], ra[0]}, {rb[W-1:1], rb[0]}, 1'(k), 1'b0);
        end

        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom); rb = W'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            glitch = int'($urandom_range(0, 4));
            applyStimulus(ra, rb, rc, rs);
            checkOp($sformatf("rnd%0d", n), ra, rb, rc, rs, glitch);
            while ($urandom_range(0, 1) == 1 && n < 23) begin
                n++;
                ra = W'($urandom); rb = W'($urandom);
                rc = 1'($urandom); rs = 1'($urandom);
                applyStimulus(ra, rb, rc, rs);
                checkOp($sformatf("rnd%0d", n), ra, rb, rc, rs, 0);
            end
            checkIdle($sformatf("rnd%0d", n), ra, rb, rc, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
